// File: rtl/game_countdown_if.sv
// Signal bundle between the round countdown timer and its controller/consumers.
// The master drives strobes and pulses; the slave (timer) drives display and status.
interface game_countdown_if;
    logic       clk_1ms;
    logic       start;
    logic       pause;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [9:0] ms_count;
    logic       running;
    logic       time_up;
    logic [1:0] state_dbg;

    // No valid/ready handshake here: start, pause and clk_1ms are single-cycle
    // pulses sampled on every rising clk edge, and all outputs are plain registered levels.
    modport master (
        output clk_1ms, start, pause,
        input  sec_tens, sec_ones, ms_count, running, time_up, state_dbg
    );

    modport slave (
        input  clk_1ms, start, pause,
        output sec_tens, sec_ones, ms_count, running, time_up, state_dbg
    );
endinterface

// File: rtl/game_countdown.sv
// Round countdown timer: accumulates 1 ms strobes into seconds and counts a
// two-digit BCD value down from START_SEC to 00, with pause/resume and restart.
module game_countdown #(
    parameter int START_SEC  = 60,
    parameter int MS_PER_SEC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    game_countdown_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] TENS_INIT = 4'(START_SEC / 10);
    localparam logic [3:0] ONES_INIT = 4'(START_SEC % 10);
    localparam logic [9:0] MS_LAST   = 10'(MS_PER_SEC - 1);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [9:0] ms_q, ms_d;
    logic       running_q, running_d;
    logic       time_up_q, time_up_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tens_q    <= TENS_INIT;
            ones_q    <= ONES_INIT;
            ms_q      <= '0;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            ms_q      <= ms_d;
            running_q <= running_d;
            time_up_q <= time_up_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        ms_d      = ms_q;
        time_up_d = 1'b0;

        // start beats every other input in every state, and swallows a coincident tick.
        if (bus.start) begin
            state_d = RUN;
            tens_d  = TENS_INIT;
            ones_d  = ONES_INIT;
            ms_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.clk_1ms) begin
                        if (ms_q == MS_LAST) begin
                            ms_d = '0;
                            if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                            // Only 01 can decrement to 00, so tens never underflows.
                            if (tens_q == 4'd0 && ones_q == 4'd1) begin
                                state_d   = DONE;
                                time_up_d = 1'b1;
                            end
                        end else begin
                            ms_d = ms_q + 10'd1;
                        end
                    end
                    if (bus.pause && state_d != DONE) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (bus.pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    ms_d = '0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    assign bus.sec_tens  = tens_q;
    assign bus.sec_ones  = ones_q;
    assign bus.ms_count  = ms_q;
    assign bus.running   = running_q;
    assign bus.time_up   = time_up_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_game_countdown.sv
// Bench for game_countdown: a small preset instance (3 s, 4 ms/s) and a maximum
// preset instance (99 s, 2 ms/s), checked against vector tables and a seconds/ms model.
module tb_game_countdown;
    logic clk;
    logic rst;

    game_countdown_if bus_a ();
    game_countdown_if bus_b ();

    game_countdown #(.START_SEC(3), .MS_PER_SEC(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    game_countdown #(.START_SEC(99), .MS_PER_SEC(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks   = 0;
    int failures = 0;
    int tu_cnt_a = 0;
    int tu_cnt_b = 0;

    // ---------------- reference model (seconds left + ms, plain integers) ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int   m_mode [2];
    int   m_secs [2];
    int   m_ms   [2];
    logic m_tu   [2];

    function automatic int start_sec(input int k);
        return (k == 0) ? 3 : 99;
    endfunction

    function automatic int ms_per_sec(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic model_step(input int k, input logic r, input logic s, input logic p, input logic t);
        m_tu[k] = 1'b0;
        if (r) begin
            m_mode[k] = M_IDLE;
            m_secs[k] = start_sec(k);
            m_ms[k]   = 0;
        end else if (s) begin
            m_mode[k] = M_RUN;
            m_secs[k] = start_sec(k);
            m_ms[k]   = 0;
        end else begin
            if (m_mode[k] == M_RUN && t) begin
                m_ms[k] = m_ms[k] + 1;
                if (m_ms[k] == ms_per_sec(k)) begin
                    m_ms[k]   = 0;
                    m_secs[k] = m_secs[k] - 1;
                    if (m_secs[k] == 0) begin
                        m_mode[k] = M_DONE;
                        m_tu[k]   = 1'b1;
                    end
                end
            end
            if (p) begin
                if (m_mode[k] == M_RUN) m_mode[k] = M_PAUSED;
                else if (m_mode[k] == M_PAUSED) m_mode[k] = M_RUN;
            end
        end
    endtask

    function automatic logic [19:0] model_out(input int k);
        logic [3:0] tn, on;
        tn = 4'(m_secs[k] / 10);
        on = 4'(m_secs[k] % 10);
        return {tn, on, 10'(m_ms[k]), (m_mode[k] == M_RUN), m_tu[k]};
    endfunction

    function automatic logic [19:0] dut_out(input int k);
        if (k == 0)
            return {bus_a.sec_tens, bus_a.sec_ones, bus_a.ms_count, bus_a.running, bus_a.time_up};
        return {bus_b.sec_tens, bus_b.sec_ones, bus_b.ms_count, bus_b.running, bus_b.time_up};
    endfunction

    // ---------------- scoreboard for the maximum preset BCD sequence ----------------
    logic [7:0] exp_q[$];
    logic       max_phase = 1'b0;
    logic [7:0] prev_b;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got t=%h o=%h ms=%0d run=%b tu=%b want t=%h o=%h ms=%0d run=%b tu=%b",
                     name, act[19:16], act[15:12], act[11:2], act[1], act[0],
                     exp[19:16], exp[15:12], exp[11:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic s, input logic p, input logic t);
        logic [7:0] cur;
        rst           = r;
        bus_a.start   = s;
        bus_a.pause   = p;
        bus_a.clk_1ms = t;
        bus_b.start   = s;
        bus_b.pause   = p;
        bus_b.clk_1ms = t;
        @(posedge clk);
        model_step(0, r, s, p, t);
        model_step(1, r, s, p, t);
        #1;
        check("model_a", dut_out(0), model_out(0));
        check("model_b", dut_out(1), model_out(1));
        if (bus_a.time_up) tu_cnt_a++;
        if (bus_b.time_up) tu_cnt_b++;
        if (max_phase) begin
            cur = {bus_b.sec_tens, bus_b.sec_ones};
            if (cur[7:4] > 4'd9 || cur[3:0] > 4'd9) begin
                checks++;
                failures++;
                $display("FAIL bcd_valid got %h want digits 0..9", cur);
            end
            if (cur != prev_b) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bcd_seq got %h want no further change", cur);
                end else begin
                    check_val("bcd_seq", int'(cur), int'(exp_q.pop_front()));
                end
            end
            prev_b = cur;
        end
    endtask

    task automatic strobe(input int gap);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic s, input logic p);
        cyc(1'b0, s, p, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- vector table for instance A (3 s, 4 ms/s) ----------------
    typedef struct packed {
        logic       s;
        logic       p;
        logic       t;
        logic [3:0] et;
        logic [3:0] eo;
        logic [9:0] ems;
        logic       er;
        logic       etu;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // row: start, pause, tick -> tens, ones, ms, running, time_up
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 10'd0, 1'b0, 1'b0}); // tick in IDLE ignored
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 10'd0, 1'b0, 1'b0}); // pause in IDLE ignored
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 10'd0, 1'b1, 1'b0}); // start
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 10'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 10'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 10'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd0, 1'b1, 1'b0}); // rollover
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 10'd2, 1'b0, 1'b0}); // pause
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd2, 1'b0, 1'b0}); // tick while paused
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 10'd2, 1'b1, 1'b0}); // resume, no reload
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 10'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 10'd0, 1'b0, 1'b0}); // pause + rollover
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 10'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 10'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 10'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 10'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 10'd0, 1'b1, 1'b0}); // start + final tick
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 10'd0, 1'b1, 1'b0}); // start + pause
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset values
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_a", dut_out(0), {4'd0, 4'd3, 10'd0, 1'b0, 1'b0});
        check("reset_b", dut_out(1), {4'd9, 4'd9, 10'd0, 1'b0, 1'b0});

        // Table-driven vectors, one input cycle then four quiet cycles per row
        for (int v = 0; v < vecs.size(); v++) begin
            cyc(1'b0, vecs[v].s, vecs[v].p, vecs[v].t);
            check($sformatf("vec[%0d]", v), dut_out(0),
                  {vecs[v].et, vecs[v].eo, vecs[v].ems, vecs[v].er, vecs[v].etu});
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Full round: 12 strobes, exactly one time_up coincident with 00
        pulse(1'b1, 1'b0);
        tu_cnt_a = 0;
        for (int n = 1; n <= 12; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (n % 4 == 0)
                check_val($sformatf("round_digit_%0d", n), int'(bus_a.sec_ones), 3 - n / 4);
            if (n == 12)
                check("round_end", dut_out(0), {4'd0, 4'd0, 10'd0, 1'b0, 1'b1});
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 3; n++) strobe(4);
        check("done_holds", dut_out(0), {4'd0, 4'd0, 10'd0, 1'b0, 1'b0});
        check_val("round_time_up_count", tu_cnt_a, 1);

        // Pause and resume
        pulse(1'b1, 1'b0);
        tu_cnt_a = 0;
        for (int n = 0; n < 6; n++) strobe(4);
        check("pr_before", dut_out(0), {4'd0, 4'd2, 10'd2, 1'b1, 1'b0});
        pulse(1'b0, 1'b1);
        for (int n = 0; n < 10; n++) strobe(4);
        check("pr_paused", dut_out(0), {4'd0, 4'd2, 10'd2, 1'b0, 1'b0});
        pulse(1'b0, 1'b1);
        for (int n = 0; n < 5; n++) strobe(4);
        check("pr_almost", dut_out(0), {4'd0, 4'd1, 10'd3, 1'b1, 1'b0});
        strobe(4);
        check("pr_done", dut_out(0), {4'd0, 4'd0, 10'd0, 1'b0, 1'b0});
        check_val("pr_time_up_count", tu_cnt_a, 1);

        // Reset mid-round at 01
        pulse(1'b1, 1'b0);
        for (int n = 0; n < 8; n++) strobe(4);
        check("mid_before", dut_out(0), {4'd0, 4'd1, 10'd0, 1'b1, 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_reset", dut_out(0), {4'd0, 4'd3, 10'd0, 1'b0, 1'b0});
        for (int n = 0; n < 3; n++) strobe(4);
        check("mid_idle", dut_out(0), {4'd0, 4'd3, 10'd0, 1'b0, 1'b0});

        // Maximum preset on instance B: 99 down to 00 through every BCD value
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        tu_cnt_b = 0;
        exp_q.delete();
        for (int n = 98; n >= 0; n--) exp_q.push_back(8'({4'(n / 10), 4'(n % 10)}));
        prev_b    = {bus_b.sec_tens, bus_b.sec_ones};
        max_phase = 1'b1;
        for (int n = 0; n < 99 * 2 + 4; n++) strobe(2);
        max_phase = 1'b0;
        check_val("max_seq_left", exp_q.size(), 0);
        check_val("max_time_up_count", tu_cnt_b, 1);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
